maverik_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-port 8-bit program/data RAM of the maverik core between the instruction-fetch path and the load/store datapath. Each port uses a level-request / one-cycle-ack handshake. The arbiter serialises accesses, drives the RAM control signals, waits out the RAM read latency, and returns registered read data. It sits between the core's fetch/execute logic and the memory that produces mem_out.

---
 rtl/maverik_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_maverik_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maverik_mem_arbiter.sv
// maverik_mem_arbiter: shares the single-port program/data RAM between the
// instruction-fetch port and the load/store port. Round-robin on ties,
// one access in flight, all outputs registered.
module maverik_mem_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;        // 1 = data port, 0 = fetch port
  logic              last_grant_q, last_grant_d;
  logic              is_write_q, is_write_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              gnt;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    gnt          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          // On a tie the port that did not win last time goes next
          gnt          = (if_req && d_req) ? ~last_grant_q : d_req;
          grant_d      = gnt;
          last_grant_d = gnt;
          is_write_d   = gnt & d_we;
          state_d      = StIssue;
          // Strobe is registered here so it is high during the ISSUE cycle
          mem_en_d     = 1'b1;
          mem_we_d     = gnt & d_we;
          mem_addr_d   = gnt ? d_addr : if_addr;
          mem_wdata_d  = gnt ? d_wdata : mem_wdata_q;
        end
      end
      StIssue: begin
        if (is_write_q) begin
          state_d  = StAck;
          if_ack_d = ~grant_q;
          d_ack_d  = grant_q;
        end else begin
          state_d = StWait;
          cnt_d   = 3'(MEM_LAT);
        end
      end
      StWait: begin
        if (cnt_q == 3'd1) begin
          state_d  = StAck;
          if_ack_d = ~grant_q;
          d_ack_d  = grant_q;
          if (grant_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_maverik_mem_arbiter.sv
// Directed bench: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
// Both share request inputs; each has its own RAM model.
module tb_maverik_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst, preload;
  logic       if_req, d_req, d_we;
  logic [7:0] if_addr, d_addr, d_wdata;

  logic       a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;
  logic [7:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
  logic [7:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maverik_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  maverik_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // RAM models: read data is valid only MEM_LAT cycles after the strobe, 0xEE otherwise
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] b_p0, b_p1;

  always @(posedge clk) begin
    if (preload) begin
      ram_a[8'h00] <= 8'h01; ram_a[8'h02] <= 8'h00; ram_a[8'h10] <= 8'hA5;
    end else if (a_mem_en && a_mem_we) begin
      ram_a[a_mem_addr] <= a_mem_wdata;
    end
    a_mem_rdata <= (a_mem_en && !a_mem_we) ? ram_a[a_mem_addr] : 8'hEE;
  end

  always @(posedge clk) begin
    if (preload) begin
      ram_b[8'h00] <= 8'h01; ram_b[8'h02] <= 8'h00; ram_b[8'h10] <= 8'hA5;
    end else if (b_mem_en && b_mem_we) begin
      ram_b[b_mem_addr] <= b_mem_wdata;
    end
    b_p0        <= (b_mem_en && !b_mem_we) ? ram_b[b_mem_addr] : 8'hEE;
    b_p1        <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic test_reset();
    preload = 1'b1; rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_mem_en, a_mem_we, a_if_ack, a_d_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000",
                         {a_busy, a_mem_en, a_mem_we, a_if_ack, a_d_ack});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata} !== 16'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h want 0000", {a_mem_addr, a_mem_wdata});
    end
    checks++;
    if ({a_if_rdata, a_d_rdata} !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0000", {a_if_rdata, a_d_rdata});
    end
    rst = 1'b0; preload = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL fetch_issue: got en/we/addr %b%b/%h want 10/00",
                         a_mem_en, a_mem_we, a_mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_if_ack} !== 2'b00) begin
      errors++; $display("FAIL fetch_wait: got en/ack %b%b want 00", a_mem_en, a_if_ack);
    end
    @(negedge clk);
    checks++;
    if ({a_if_ack, a_d_ack, a_if_rdata} !== {2'b10, 8'h01}) begin
      errors++; $display("FAIL fetch_ack: got ack %b%b rdata %h want 10 01",
                         a_if_ack, a_d_ack, a_if_rdata);
    end
    if_req = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h02; d_wdata = 8'h02;
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 8'h02, 8'h02}) begin
      errors++; $display("FAIL write_issue: got %b%b %h %h want 11 02 02",
                         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({a_d_ack, a_if_ack, a_mem_en, a_mem_we} !== 4'b1000) begin
      errors++; $display("FAIL write_ack: got %b want 1000",
                         {a_d_ack, a_if_ack, a_mem_en, a_mem_we});
    end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_d_ack, a_d_rdata, a_if_rdata} !== {1'b1, 8'h02, 8'h01}) begin
      errors++; $display("FAIL read_back: got ack %b d %h if %h want 1 02 01",
                         a_d_ack, a_d_rdata, a_if_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ord [4];
    int k = 0;
    logic both = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (a_if_ack && a_d_ack) both = 1'b1;
      else if (a_if_ack) begin ord[k] = 0; k++; end
      else if (a_d_ack) begin ord[k] = 1; k++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL b2b_count: got %0d acks want 4", k);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++; $display("FAIL b2b_dual_ack: got %b want 0", both);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (ord[i] != (i % 2)) begin
        errors++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, ord[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    logic seen = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10;
    repeat (2) @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_busy, a_mem_en, a_if_ack, a_if_rdata} !== {3'b000, 8'h00}) begin
      errors++; $display("FAIL rst_wait: got busy/en/ack %b%b%b rdata %h want 000 00",
                         a_busy, a_mem_en, a_if_ack, a_if_rdata);
    end
    repeat (6) begin
      @(negedge clk);
      if (a_if_ack) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_ack: got %b want 0", seen);
    end
    // last_grant was reset, so the fetch port wins this tie
    if_req = 1'b1; if_addr = 8'h00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    while (!a_if_ack && !a_d_ack && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if ({a_if_ack, a_d_ack, a_if_rdata} !== {2'b10, 8'h01} || n != 3) begin
      errors++; $display("FAIL rst_tie: got ack %b%b rdata %h at %0d want 10 01 at 3",
                         a_if_ack, a_d_ack, a_if_rdata, n);
    end
    if_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a_d_ack && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if ({a_d_ack, a_d_rdata} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL rst_tie_data: got ack %b rdata %h want 1 02", a_d_ack, a_d_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_pulse_ignored();
    logic seen_ack = 1'b0;
    logic seen_en = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_d_ack, a_d_rdata} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL pulse_data: got ack %b rdata %h want 1 a5", a_d_ack, a_d_rdata);
    end
    d_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (a_if_ack) seen_ack = 1'b1;
      if (a_mem_en) seen_en = 1'b1;
    end
    checks++;
    if ({seen_ack, seen_en, a_if_rdata} !== {2'b00, 8'h01}) begin
      errors++; $display("FAIL pulse_fetch: got ack/en %b%b if_rdata %h want 00 01",
                         seen_ack, seen_en, a_if_rdata);
    end
  endtask

  task automatic test_lat3();
    int n = 0;
    logic en1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    while (!b_if_ack && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 5 || b_if_rdata !== 8'h01) begin
      errors++; $display("FAIL lat3_fetch: got at %0d rdata %h want at 5 rdata 01", n, b_if_rdata);
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    n = 1;
    @(negedge clk);
    en1 = b_mem_en;
    while (!b_d_ack && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 5 || en1 !== 1'b1) begin
      errors++; $display("FAIL lat3_timing: got ack at %0d en %b want at 5 en 1", n, en1);
    end
    checks++;
    if ({b_d_rdata, b_if_rdata, b_if_ack} !== {8'hA5, 8'h01, 1'b0}) begin
      errors++; $display("FAIL lat3_data: got d %h if %h if_ack %b want a5 01 0",
                         b_d_rdata, b_if_rdata, b_if_ack);
    end
    d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_back_to_back();
    test_reset_in_wait();
    test_pulse_ignored();
    test_lat3();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
